// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the LemonPC load/store writeback stage.
// funct3 encodings, FSM state enum, access-size decode and byte-lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  // Undefined funct3 encodings fall back to word size; stores have no unsigned forms.
  function automatic mem_size_t mem_size(input logic [2:0] f3, input logic is_store);
    mem_size_t sz;
    if (is_store) begin
      case (f3)
        F3_B:    sz = SZ_B;
        F3_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input mem_size_t sz);
    logic [31:0] res;
    case (sz)
      SZ_B:    res = addr;
      SZ_H:    res = {addr[31:1], 1'b0};
      default: res = {addr[31:2], 2'b00};
    endcase
    return res;
  endfunction

  function automatic logic [3:0] lane_strobe(input mem_size_t sz, input logic [1:0] off);
    logic [3:0] res;
    case (sz)
      SZ_B:    res = 4'b0001 << off;
      SZ_H:    res = 4'b0011 << off;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] replicate(input mem_size_t sz, input logic [31:0] data);
    logic [31:0] res;
    case (sz)
      SZ_B:    res = {4{data[7:0]}};
      SZ_H:    res = {2{data[15:0]}};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment: shifts the addressed lane down and sign/zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  // Lane shift then size-dependent extension; word and undefined encodings pass through.
  always_comb begin
    shifted_s = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    result = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_BU:   result = {24'h000000, shifted_s[7:0]};
      F3_HU:   result = {16'h0000, shifted_s[15:0]};
      default: result = shifted_s;
    endcase
  end

endmodule

// File: rtl/lsu_writeback.sv
// Memory-access and writeback stage: one instruction at a time, IDLE/REQ/WAIT/WB.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of aligning them.
module lsu_writeback
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_load,
  input  logic                  in_store,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rf_wen,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [3:0]            mem_req_wstrb,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  output logic                  exc_misaligned
);

  lsu_state_t            state_r, state_next_s;
  logic                  load_r, store_r, wen_r;
  logic [2:0]            f3_r;
  logic [DATA_WIDTH-1:0] addr_r, wdata_r, wb_data_r, ext_s;
  logic [3:0]            wstrb_r;
  logic [ADDR_WIDTH-1:0] rd_r;
  mem_size_t             size_s;
  logic [DATA_WIDTH-1:0] aligned_addr_s;
  logic                  is_mem_s, misalign_s;

  assign is_mem_s       = in_load | in_store;
  assign size_s         = mem_size(in_funct3, in_store);
  assign aligned_addr_s = align_addr(in_addr, size_s);
`ifdef LSU_MISALIGN_TRAP_EN
  logic exc_r;
  assign misalign_s     = is_mem_s & (aligned_addr_s[1:0] != in_addr[1:0]);
  assign exc_misaligned = (state_r == ST_WB) & exc_r;
`else
  assign misalign_s     = 1'b0;
  assign exc_misaligned = 1'b0;
`endif

  load_extend u_load_extend (
    .rdata   (mem_resp_rdata),
    .addr_lo (addr_r[1:0]),
    .funct3  (f3_r),
    .result  (ext_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a trapped access reuses WB as its one-cycle pulse state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_mem_s && !misalign_s) state_next_s = ST_REQ;
          else                         state_next_s = ST_WB;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_next_s = ST_WAIT;
        else               state_next_s = ST_REQ;
      end
      ST_WAIT: begin
        if (mem_resp_valid) state_next_s = load_r ? ST_WB : ST_IDLE;
        else                state_next_s = ST_WAIT;
      end
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Instruction latch at accept and load-data capture on the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_r    <= 1'b0;
      store_r   <= 1'b0;
      wen_r     <= 1'b0;
      f3_r      <= 3'b000;
      addr_r    <= '0;
      wdata_r   <= '0;
      wstrb_r   <= 4'b0000;
      rd_r      <= '0;
      wb_data_r <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            load_r    <= in_load;
            store_r   <= in_store;
            wen_r     <= in_rf_wen & (in_rd != '0) & ~in_store & ~misalign_s;
            f3_r      <= in_funct3;
            addr_r    <= aligned_addr_s;
            wstrb_r   <= in_store ? lane_strobe(size_s, aligned_addr_s[1:0]) : 4'b0000;
            wdata_r   <= in_store ? replicate(size_s, in_wdata) : '0;
            rd_r      <= in_rd;
            wb_data_r <= in_alu_result;
`ifdef LSU_MISALIGN_TRAP_EN
            exc_r     <= misalign_s;
`endif
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid && load_r) wb_data_r <= ext_s;
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state_r == ST_IDLE);
  assign mem_req_valid = (state_r == ST_REQ);
  assign mem_req_addr  = {addr_r[DATA_WIDTH-1:2], 2'b00};
  assign mem_req_wen   = store_r;
  assign mem_req_wstrb = wstrb_r;
  assign mem_req_wdata = wdata_r;
  assign rf_wen        = (state_r == ST_WB) & wen_r;
  assign rf_rd         = rd_r;
  assign rf_dataD      = wb_data_r;

endmodule

// File: tb/tb_lsu_writeback.sv
// Randomized self-checking bench for lsu_writeback against a byte-arithmetic reference model.
module tb_lsu_writeback;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_load = 1'b0, in_store = 1'b0, in_rf_wen = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_addr = 32'd0, in_wdata = 32'd0, in_alu_result = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = 32'd0;
  logic        rf_wen, exc_misaligned;
  logic [4:0]  rf_rd;
  logic [31:0] rf_dataD;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_rf_wen(in_rf_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD),
    .exc_misaligned(exc_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction end to end; expectations come from byte arithmetic on the access.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] alu, input logic [4:0] rd, input bit wen,
                       input logic [31:0] rdata, input int rdly, input int wdly,
                       input bit stray);
    int          sz, off;
    longint      v;
    bit          trap, exp_wen;
    logic [31:0] exp_word, exp_wdat, exp_res;
    logic [3:0]  exp_strb;

    if (st) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    off      = int'(addr % 32'd4);
    trap     = TRAP_EN && (ld || st) && (off % sz != 0);
    off      = off - (off % sz);
    exp_word = addr - (addr % 32'd4);
    exp_strb = st ? 4'(((1 << sz) - 1) << off) : 4'd0;
    exp_wdat = (sz == 1) ? (wdata % 32'd256) * 32'h01010101 :
               (sz == 2) ? (wdata % 32'd65536) * 32'h00010001 : wdata;
    v = longint'(rdata >> (8 * off));
    if (sz < 4) begin
      v = v % (64'sd1 << (8 * sz));
      if ((f3 == 3'd0 || f3 == 3'd1) && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
    end
    exp_res = (ld || st) ? v[31:0] : alu;
    exp_wen = wen && (rd != 5'd0) && !st && !trap;

    check_val("ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3; in_addr = addr;
    in_wdata = wdata; in_alu_result = alu; in_rd = rd; in_rf_wen = wen;
    step();
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_alu_result = $urandom;
    in_rd = 5'($urandom); in_funct3 = 3'($urandom);

    if (!ld && !st) begin
      check_val("alu_rf_wen", {31'd0, rf_wen}, {31'd0, exp_wen});
      if (exp_wen) begin
        check_val("alu_rf_rd", {27'd0, rf_rd}, {27'd0, rd});
        check_val("alu_rf_data", rf_dataD, exp_res);
      end
      check_val("alu_no_req", {31'd0, mem_req_valid}, 32'd0);
      step();
      check_val("alu_ready_back", {31'd0, in_ready}, 32'd1);
      check_val("alu_wen_pulse", {31'd0, rf_wen}, 32'd0);
      return;
    end

    if (trap) begin
      check_val("trap_exc", {31'd0, exc_misaligned}, 32'd1);
      check_val("trap_no_req", {31'd0, mem_req_valid}, 32'd0);
      check_val("trap_no_wen", {31'd0, rf_wen}, 32'd0);
      step();
      check_val("trap_ready_back", {31'd0, in_ready}, 32'd1);
      check_val("trap_exc_pulse", {31'd0, exc_misaligned}, 32'd0);
      return;
    end

    for (int i = 0; i <= rdly; i++) begin
      check_val("req_valid", {31'd0, mem_req_valid}, 32'd1);
      check_val("req_addr", mem_req_addr, exp_word);
      check_val("req_wen", {31'd0, mem_req_wen}, {31'd0, st});
      check_val("req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, exp_strb});
      if (st) check_val("req_wdata", mem_req_wdata, exp_wdat);
      mem_resp_valid = stray;
      mem_req_ready  = (i == rdly);
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
    end

    for (int j = 0; j <= wdly; j++) begin
      check_val("wait_no_req", {31'd0, mem_req_valid}, 32'd0);
      check_val("wait_not_ready", {31'd0, in_ready}, 32'd0);
      check_val("wait_no_wen", {31'd0, rf_wen}, 32'd0);
      mem_req_ready = 1'($urandom);
      if (j == wdly) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
      end
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
    end

    if (ld) begin
      check_val("ld_rf_wen", {31'd0, rf_wen}, {31'd0, exp_wen});
      if (exp_wen) begin
        check_val("ld_rf_rd", {27'd0, rf_rd}, {27'd0, rd});
        check_val("ld_rf_data", rf_dataD, exp_res);
      end
      step();
      check_val("ld_ready_back", {31'd0, in_ready}, 32'd1);
      check_val("ld_wen_pulse", {31'd0, rf_wen}, 32'd0);
    end else begin
      check_val("st_ready_back", {31'd0, in_ready}, 32'd1);
      check_val("st_no_wen", {31'd0, rf_wen}, 32'd0);
    end
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    step();
    step();
    rst = 1'b0;
    check_val("rst_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_val("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    check_val("rst_req_addr", mem_req_addr, 32'd0);
    check_val("rst_rf_data", rf_dataD, 32'd0);
    check_val("rst_exc", {31'd0, exc_misaligned}, 32'd0);

    do_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'hDEADBEEF, 5'd5, 1'b1, 32'd0, 0, 0, 1'b0);
    do_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'hDEADBEEF, 5'd0, 1'b1, 32'd0, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd0, 32'h1003, 32'd0, 32'd0, 5'd7, 1'b1, 32'h80FF_0000, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd4, 32'h1003, 32'd0, 32'd0, 5'd7, 1'b1, 32'h80FF_0000, 0, 0, 1'b0);
    do_op(1'b0, 1'b1, 3'd1, 32'h2002, 32'h1234_ABCD, 32'd0, 5'd3, 1'b1, 32'd0, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd2, 32'h3000, 32'd0, 32'd0, 5'd9, 1'b1, 32'hCAFE_F00D, 3, 2, 1'b1);
    do_op(1'b1, 1'b0, 3'd2, 32'h1001, 32'd0, 32'd0, 5'd4, 1'b1, 32'h1111_2222, 0, 0, 1'b0);

    // Reset while waiting for a load response.
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'd2;
    in_addr = 32'h4000; in_rd = 5'd6; in_rf_wen = 1'b1;
    step();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check_val("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_val("mid_rst_req_addr", mem_req_addr, 32'd0);
    check_val("mid_rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    check_val("mid_rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_AAAA;
    step();
    mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("late_resp_no_wen", {31'd0, rf_wen}, 32'd0);
      check_val("late_resp_ready", {31'd0, in_ready}, 32'd1);
      step();
    end

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(2, 0));
      do_op(kind == 1, kind == 2, f3_tab[$urandom_range(7, 0)], $urandom, $urandom,
            $urandom, 5'($urandom), 1'($urandom), $urandom,
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_writeback.md
# lsu_writeback

Memory-access and writeback stage of the LemonPC multi-cycle core. Accepts one decoded instruction at a time from execute, performs the load/store handshake with the data-memory port, aligns and sign/zero-extends load data, and drives the register file write port (`rf_wen`/`rf_rd`/`rf_dataD`). Non-memory instructions pass their ALU result straight through to writeback.

## Interface
- `DATA_WIDTH`, 32, data and address width; only 32 is supported.
- `ADDR_WIDTH`, 5, register index width.
- `clk  in  1  clock; all state changes on posedge`
- `rst  in  1  reset, synchronous, active-high`
- `in_valid  in  1  execute has an instruction`
- `in_ready  out  1  stage can accept; high only in IDLE`
- `in_load / in_store  in  1  memory op class; both low = ALU op; both high is illegal`
- `in_funct3  in  3  size/sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101`
- `in_addr  in  DATA_WIDTH  effective byte address`
- `in_wdata  in  DATA_WIDTH  store data, LSB-aligned`
- `in_alu_result  in  DATA_WIDTH  writeback value for ALU ops`
- `in_rd  in  ADDR_WIDTH  destination register`
- `in_rf_wen  in  1  instruction writes rd`
- `mem_req_valid  out  1  request valid`
- `mem_req_ready  in  1  memory accepts the request`
- `mem_req_addr  out  DATA_WIDTH  word address; bits [1:0] always 0`
- `mem_req_wen  out  1  1 = write`
- `mem_req_wstrb  out  4  byte-lane enables; 0000 on reads`
- `mem_req_wdata  out  DATA_WIDTH  lane-shifted store data`
- `mem_resp_valid  in  1  response; read data valid, or write acknowledged`
- `mem_resp_rdata  in  DATA_WIDTH  full word read`
- `rf_wen  out  1  register write strobe, one-cycle pulse`
- `rf_rd  out  ADDR_WIDTH  write index`
- `rf_dataD  out  DATA_WIDTH  write data`
- `exc_misaligned  out  1  one-cycle misaligned-access pulse`

## Operation
- States: IDLE, REQ, WAIT, WB.
- IDLE: `in_ready` = 1. On `in_valid`, latch all `in_*` fields.
  - ALU op goes to WB.
  - Load or store goes to REQ.
- REQ: `mem_req_valid` = 1. Address, `wen`, strobe and data are held stable until `mem_req_ready`; on that edge go to WAIT.
- WAIT: on `mem_resp_valid`:
  - Load: capture `rdata`, go to WB.
  - Store: go to IDLE.
- WB: `rf_wen` = latched `in_rf_wen` && `rd != 0`. Data is the ALU result or the extended load value. Go to IDLE.
- Store lanes:
  - SB: strobe `0001 << addr[1:0]`, data = byte replicated ×4.
  - SH: strobe `0011 << addr[1:0]`, data = half replicated ×2.
  - SW: strobe `1111`.
- Load extract: shift `rdata` right by 8·`addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
- Undefined `funct3` on a memory op: treat as W size.
- `mem_resp_valid` outside WAIT is ignored. `mem_req_ready` outside REQ is ignored.
- Store responses never produce `rf_wen`.

## Timing
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- Reset: state = IDLE; `in_ready` = 1; every other output = 0.
- Reset mid-transaction abandons the operation. `mem_req_valid` is 0 in the cycle after the reset edge, and no `rf_wen` is issued.
- ALU op accepted at edge N: `rf_wen` high in cycle N+1; `in_ready` high again in N+2.
- Load accepted at N, with `mem_req_ready` high in N+1 and `mem_resp_valid` in N+2: `rf_wen` in N+3. Each extra memory wait cycle adds one cycle.
- Store with the same memory timing: `in_ready` high again in N+3.
- A response can never be consumed in the same cycle as its request handshake.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned H (`addr[0]`) or W (`addr[1:0] != 0`) accesses skip REQ.
  - `exc_misaligned` pulses for one cycle; no memory request and no `rf_wen`.
  - Return to IDLE; the next accept is possible the cycle after the pulse.
- Undefined: `exc_misaligned` is tied 0. Offending low address bits are cleared to the natural alignment (H clears bit 0, W clears bits [1:0]) and the access proceeds normally.

## Structure
- `lsu_pkg`:
  - `funct3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - State enum `lsu_state_t`.
  - Strobe and replicate helper functions.
- Sub-module `load_extend`: combinational; `rdata`, `addr[1:0]`, `funct3` → 32-bit extended value. Instantiated once.

## Test plan
- ALU op, `rd`=5, result `0xDEADBEEF` → `rf_wen` pulse one cycle after accept, `rf_rd`=5, `rf_dataD`=`0xDEADBEEF`; same op with `rd`=0 → no `rf_wen`.
- LB at `0x1003`, `rdata` `0x80FF_0000` → `mem_req_addr` `0x1000`, `wstrb` `0000`, `rf_dataD` `0xFFFF_FF80`; LBU → `0x0000_0080`.
- SH at `0x2002`, `wdata` `0x1234_ABCD` → `wstrb` `1100`, `wdata` `0xABCD_ABCD`, no `rf_wen`; `in_ready` returns the cycle after the response.
- `mem_req_ready` held low 3 cycles, plus a stray `mem_resp_valid` during REQ → request fields stay stable, stray response ignored, LW completes with the true response.
- With `LSU_MISALIGN_TRAP_EN`: LW at `0x1001` → `exc_misaligned` one pulse, no `mem_req_valid`, no `rf_wen`. Without it: request at `0x1000`.
- `rst` asserted in WAIT → all outputs 0 next cycle, `in_ready`=1, late `mem_resp_valid` ignored, no `rf_wen`.
